// File: rtl/ad9866_spi_sched.sv
// AD9866 serial-port scheduler: sequences the converter hardware reset, then
// arbitrates round-robin between register requesters and shifts 16-bit SPI frames.
module ad9866_spi_sched #(
   parameter int NREQ       = 3,
   parameter int CLKDIV     = 8,
   parameter int RST_CYCLES = 64,
   parameter int RST_WAIT   = 256,
   parameter int GAP_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [16*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic [1:0]        rd_src,
   output logic              busy,
   output logic              ad9866_rst_n,
   output logic              ad9866_sclk,
   output logic              ad9866_sdio,
   input  logic              ad9866_sdo,
   output logic              ad9866_sen_n
);
   localparam int RMAX = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
   localparam int CMAX = (RMAX > GAP_CYCLES) ? RMAX : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int PHW  = $clog2(2 * CLKDIV);

   typedef enum logic [2:0] {S_RST_HOLD, S_RST_WAIT, S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [PHW-1:0]  ph_q;
   logic [3:0]      bit_q;
   logic [1:0]      ptr_q;
   logic [1:0]      gnt_q;
   logic [15:0]     word_q;
   logic [7:0]      shreg_q;
   logic [7:0]      shreg_d;
   logic            any_d;
   logic [1:0]      gnt_d;
   logic [15:0]     gword_d;
   logic [NREQ-1:0] gnt_oh_d;
   logic            sdio_d;
   logic [2:0]      sum;
   logic [3:0]      nxt_bit;

   // Nearest valid index after the pointer wins; scanning far-to-near lets k=1 override.
   always_comb begin
      any_d    = 1'b0;
      gnt_d    = ptr_q;
      sum      = '0;
      gnt_oh_d = '0;
      for (int k = NREQ; k >= 1; k--) begin
         sum = {1'b0, ptr_q} + 3'(k);
         if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
         if (req_valid[sum[1:0]]) begin
            any_d = 1'b1;
            gnt_d = sum[1:0];
         end
      end
      gnt_oh_d[gnt_d] = 1'b1;
      gword_d = req_data[{gnt_d, 4'b0000} +: 16];
   end

   always_comb begin
      nxt_bit = 4'd14 - bit_q;
      sdio_d  = (word_q[15] && bit_q >= 4'd7) ? 1'b0 : word_q[nxt_bit];
      shreg_d = shreg_q;
      if (state_q == S_SHIFT && ph_q == PHW'(CLKDIV) && bit_q >= 4'd8)
         shreg_d = {shreg_q[6:0], ad9866_sdo};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_RST_HOLD;
         cnt_q        <= '0;
         ph_q         <= '0;
         bit_q        <= '0;
         ptr_q        <= 2'(NREQ - 1);
         gnt_q        <= '0;
         word_q       <= '0;
         shreg_q      <= '0;
         req_ready    <= '0;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         rd_src       <= '0;
         busy         <= 1'b1;
         ad9866_rst_n <= 1'b0;
         ad9866_sclk  <= 1'b0;
         ad9866_sdio  <= 1'b0;
         ad9866_sen_n <= 1'b1;
      end else begin
         req_ready <= '0;
         rd_valid  <= 1'b0;
         shreg_q   <= shreg_d;
         case (state_q)
            S_RST_HOLD: begin
               if (cnt_q == CW'(RST_CYCLES - 1)) begin
                  state_q      <= S_RST_WAIT;
                  cnt_q        <= '0;
                  ad9866_rst_n <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RST_WAIT: begin
               if (cnt_q == CW'(RST_WAIT - 1)) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_IDLE: begin
               if (any_d) begin
                  state_q      <= S_LOAD;
                  req_ready    <= gnt_oh_d;
                  gnt_q        <= gnt_d;
                  ptr_q        <= gnt_d;
                  word_q       <= gword_d;
                  ad9866_sen_n <= 1'b0;
                  ad9866_sdio  <= gword_d[15];
                  busy         <= 1'b1;
               end
            end
            S_LOAD: begin
               state_q <= S_SHIFT;
               ph_q    <= '0;
               bit_q   <= '0;
            end
            S_SHIFT: begin
               if (ph_q == PHW'(2 * CLKDIV - 1)) begin
                  ph_q        <= '0;
                  ad9866_sclk <= 1'b0;
                  if (bit_q == 4'd15) begin
                     state_q      <= S_GAP;
                     cnt_q        <= '0;
                     ad9866_sen_n <= 1'b1;
                     ad9866_sdio  <= 1'b0;
                     if (word_q[15]) begin
                        rd_valid <= 1'b1;
                        rd_data  <= shreg_d;
                        rd_src   <= gnt_q;
                     end
                  end else begin
                     bit_q       <= bit_q + 1'b1;
                     ad9866_sdio <= sdio_d;
                  end
               end else begin
                  ph_q <= ph_q + 1'b1;
                  if (ph_q == PHW'(CLKDIV - 1)) ad9866_sclk <= 1'b1;
               end
            end
            S_GAP: begin
               if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_RST_HOLD;
         endcase
      end
   end
endmodule

// File: tb/tb_ad9866_spi_sched.sv
// Bench for ad9866_spi_sched: table of single requests plus reset, round-robin,
// abort and withdrawn-request sequences, checked through a frame scoreboard.
module tb_ad9866_spi_sched;
   localparam int NREQ = 3, CLKDIV = 2, RSTC = 4, RSTW = 8, GAP = 4;
   localparam int FLEN = 1 + 32 * CLKDIV;

   typedef struct {
      int          src;
      logic [15:0] bits;
      logic        rd;
      logic [7:0]  rbyte;
   } exp_t;

   typedef struct {
      int          src;
      logic [15:0] word;
      logic [7:0]  sdo;
      logic [15:0] exp_bits;
      logic        exp_rd;
      logic [7:0]  exp_byte;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req_valid;
   logic [47:0] req_data;
   logic [2:0]  req_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [1:0]  rd_src;
   logic        busy;
   logic        ad9866_rst_n, ad9866_sclk, ad9866_sdio, ad9866_sdo, ad9866_sen_n;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   vec_t vecs[8];
   logic [7:0] sdo_byte = 8'h00;

   int          p = 0;
   int          flen = 0;
   int          nbits = 0;
   int          last_end = -1000;
   logic        in_frame = 1'b0;
   logic        prev_sclk = 1'b0;
   logic [15:0] bits = '0;

   ad9866_spi_sched #(.NREQ(NREQ), .CLKDIV(CLKDIV), .RST_CYCLES(RSTC),
                      .RST_WAIT(RSTW), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_src(rd_src),
      .busy(busy), .ad9866_rst_n(ad9866_rst_n), .ad9866_sclk(ad9866_sclk),
      .ad9866_sdio(ad9866_sdio), .ad9866_sdo(ad9866_sdo), .ad9866_sen_n(ad9866_sen_n));

   always #5 clk = ~clk;

   // Converter model: bit period p carries read-data bit 15-p during the data phase.
   assign ad9866_sdo = (p >= 8 && p <= 15) ? sdo_byte[15 - p] : 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   initial begin
      exp_t e;
      logic fe;
      forever begin
         @(negedge clk);
         fe = 1'b0;
         if (rst) begin
            in_frame  = 1'b0;
            last_end  = -1000;
            prev_sclk = 1'b0;
            p         = 0;
         end else begin
            if (req_ready != 3'b000) begin
               chk("ready_onehot", 32'($onehot(req_ready)), 1);
               chk("ready_sen_n", ad9866_sen_n, 0);
               chk("gap_before_grant", 32'((cyc - last_end) >= GAP + 1), 1);
               if (exp_q.size() == 0) chk("unexpected_grant", req_ready, 0);
               else chk("grant_src", req_ready, 32'(1) << exp_q[0].src);
               in_frame = 1'b1;
               flen = 1; nbits = 0; bits = '0; p = 0;
            end else if (in_frame) begin
               if (!ad9866_sen_n) begin
                  flen++;
                  if (ad9866_sclk && !prev_sclk) begin
                     bits = {bits[14:0], ad9866_sdio};
                     nbits++;
                  end
                  if (!ad9866_sclk && prev_sclk) p++;
               end else begin
                  in_frame = 1'b0;
                  last_end = cyc;
                  fe = 1'b1;
                  chk("frame_sclk_low", ad9866_sclk, 0);
                  if (exp_q.size() == 0) chk("frame_without_expectation", 1, 0);
                  else begin
                     e = exp_q.pop_front();
                     chk("sdio_bits", bits, e.bits);
                     chk("sclk_rises", nbits, 16);
                     chk("frame_len", flen, FLEN);
                     chk("rd_valid", rd_valid, e.rd);
                     if (e.rd) begin
                        chk("rd_data", rd_data, e.rbyte);
                        chk("rd_src", rd_src, e.src);
                     end
                  end
               end
            end
            if (rd_valid && !fe) chk("rd_valid_spurious", rd_valid, 0);
            prev_sclk = ad9866_sclk;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input int src, input logic [15:0] b, input logic r, input logic [7:0] rb);
      exp_t e;
      e.src = src; e.bits = b; e.rd = r; e.rbyte = rb;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic send(input vec_t v);
      int n = 0;
      push_exp(v.src, v.exp_bits, v.exp_rd, v.exp_byte);
      sdo_byte = v.sdo;
      req_data[16*v.src +: 16] = v.word;
      req_valid[v.src] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[v.src] && n < 500);
      chk("grant_timeout", req_ready[v.src], 1);
      req_valid[v.src] = 1'b0;
      drain();
   endtask

   // Post-reset sequence shared by the power-up and abort cases.
   task automatic reset_replay(input int src, input logic [2:0] ready_exp);
      logic early = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 3)  chk("rst_n_hold", ad9866_rst_n, 0);
         if (k == 4)  chk("rst_n_rise", ad9866_rst_n, 1);
         if (k == 11) chk("busy_in_wait", busy, 1);
         if (k < 13 && req_ready != 3'b000) early = 1'b1;
         if (k == 13) begin
            chk("first_ready", req_ready, ready_exp);
            req_valid[src] = 1'b0;
         end
         if (k == 14) chk("ready_pulse_len", req_ready, 0);
      end
      chk("no_early_ready", early, 0);
   endtask

   initial begin
      int   g[3];
      int   n;
      logic act;
      req_valid = '0;
      req_data  = '0;
      vecs[0] = '{1, 16'h0A55, 8'h00, 16'h0A55, 1'b0, 8'h00};
      vecs[1] = '{2, 16'h8F00, 8'hC3, 16'h8F00, 1'b1, 8'hC3};
      vecs[2] = '{0, 16'h80FF, 8'h5A, 16'h8000, 1'b1, 8'h5A};
      vecs[3] = '{1, 16'h7FFF, 8'h00, 16'h7FFF, 1'b0, 8'h00};
      vecs[4] = '{2, 16'hFFAA, 8'h00, 16'hFF00, 1'b1, 8'h00};
      vecs[5] = '{0, 16'h0000, 8'hFF, 16'h0000, 1'b0, 8'h00};
      vecs[6] = '{1, 16'hA5A5, 8'hFF, 16'hA500, 1'b1, 8'hFF};
      vecs[7] = '{2, 16'h2C3D, 8'h00, 16'h2C3D, 1'b0, 8'h00};

      repeat (3) @(negedge clk);
      chk("rst_rst_n", ad9866_rst_n, 0);
      chk("rst_sen_n", ad9866_sen_n, 1);
      chk("rst_sclk", ad9866_sclk, 0);
      chk("rst_sdio", ad9866_sdio, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_src", rd_src, 0);
      chk("rst_busy", busy, 1);

      // Requester 0 valid from the first cycle after reset.
      push_exp(0, 16'h1234, 1'b0, 8'h00);
      req_data[15:0] = 16'h1234;
      req_valid[0] = 1'b1;
      rst = 1'b0;
      reset_replay(0, 3'b001);
      drain();

      for (int i = 0; i < 8; i++) send(vecs[i]);

      // All requesters continuously valid: pointer sits at 2, so 0,1,2,0,1,2.
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 3; s++)
            push_exp(s, 16'h1111 << s, 1'b0, 8'h00);
      req_data = {16'h4444, 16'h2222, 16'h1111};
      g = '{0, 0, 0};
      req_valid = 3'b111;
      n = 0;
      while (req_valid != 3'b000 && n < 1500) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < 3; i++)
            if (req_ready[i]) begin
               g[i]++;
               if (g[i] == 2) req_valid[i] = 1'b0;
            end
      end
      chk("rr_all_granted", req_valid, 0);
      req_valid = '0;
      drain();

      // Asynchronous reset in the middle of bit 7; the frame restarts after RST_WAIT.
      push_exp(1, 16'h3C3C, 1'b0, 8'h00);
      req_data[31:16] = 16'h3C3C;
      req_valid[1] = 1'b1;
      n = 0;
      while (!(in_frame && nbits >= 9) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_bit7", nbits, 9);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_sen_n", ad9866_sen_n, 1);
      chk("abort_sclk", ad9866_sclk, 0);
      chk("abort_rst_n", ad9866_rst_n, 0);
      chk("abort_busy", busy, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      reset_replay(1, 3'b010);
      drain();

      // One-cycle valid during RST_WAIT must be ignored.
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      act = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 6) begin
            req_data[15:0] = 16'h8123;
            req_valid[0] = 1'b1;
         end
         if (k == 7)  req_valid[0] = 1'b0;
         if (k == 11) chk("wait_busy", busy, 1);
         if (k == 12) chk("idle_busy_falls", busy, 0);
         if (req_ready != 3'b000 || !ad9866_sen_n || ad9866_sclk) act = 1'b1;
      end
      chk("no_spi_activity", act, 0);
      chk("idle_busy_stays_low", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ad9866_spi_sched.md
Name: ad9866_spi_sched

Overview:
- Serial-port scheduler for the AD9866 control interface.
- Sequences the converter's hardware reset, then arbitrates round-robin between NREQ register-write/read requesters (power-up init table, host config, gain control) and serializes each granted 16-bit word onto the 4-wire SPI.
- Sits between the core's configuration logic and the ad9866_sclk/sdio/sdo/sen_n/rst_n pins.
- Runs in the IF_clk domain.

Parameters:
- NREQ, 3, number of requesters (2..4).
- CLKDIV, 8, clk cycles per SCLK half-period (>=1).
- RST_CYCLES, 64, clk cycles ad9866_rst_n is held low after reset.
- RST_WAIT, 256, clk cycles after ad9866_rst_n rises before the first frame.
- GAP_CYCLES, 4, minimum clk cycles sen_n stays high between frames (>=1).

Ports:
- clk  in  1  IF_clk, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request i pending; word held stable until req_ready[i].
- req_data  in  16*NREQ  word i at [16i+15:16i]: bit15 = R/W (1 = read), [14:8] = address, [7:0] = write data.
- req_ready  out  NREQ  one-cycle grant/accept pulse, at most one bit set.
- rd_data  out  8  byte captured by the last read frame.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- rd_src  out  2  requester index of the read, valid with rd_valid.
- busy  out  1  high in every state except IDLE.
- ad9866_rst_n  out  1  converter hardware reset, active low.
- ad9866_sclk  out  1  SPI clock, idles low.
- ad9866_sdio  out  1  SPI data to converter.
- ad9866_sdo  in  1  SPI data from converter.
- ad9866_sen_n  out  1  SPI enable, active low.

Behaviour:
- Reset values (asserted asynchronously):
  - ad9866_rst_n=0, ad9866_sen_n=1, ad9866_sclk=0, ad9866_sdio=0.
  - req_ready=0, rd_valid=0, rd_data=0, rd_src=0, busy=1.
  - RR pointer = NREQ-1, so requester 0 wins first.
  - State = RST_HOLD.
- Reset mid-frame aborts the frame immediately. No partial-frame completion; no req_ready is issued.
- States: RST_HOLD -> RST_WAIT -> IDLE -> LOAD -> SHIFT -> GAP -> IDLE.
- RST_HOLD: lasts RST_CYCLES cycles with rst_n=0. Then rst_n=1 and go to RST_WAIT.
- RST_WAIT: lasts RST_WAIT cycles, then IDLE. req_valid is ignored in both reset states.
- IDLE: if any req_valid, grant the first set index after the RR pointer, cyclically. Move to LOAD next cycle.
- LOAD (1 cycle):
  - req_ready[g]=1; latch word and g; update pointer to g.
  - sen_n=0; sdio = bit15.
  - Request-to-ready latency: 1 cycle from IDLE sampling valid.
- SHIFT: 16 bit periods of 2*CLKDIV cycles each, MSB first.
  - sclk is low for the first CLKDIV cycles of a period, high for the second.
  - sdio changes only at each falling edge (period start); the converter samples on rising edges.
  - Reads: sdio=0 for bits 7..0. sdo is sampled in the clk cycle in which sclk rises, for bits 7..0, into a shift register.
  - After the last high half-period: sclk=0, sen_n=1, go to GAP.
  - Frame length (sen_n low): exactly 1 + 32*CLKDIV cycles, counting LOAD.
- GAP: lasts GAP_CYCLES cycles.
  - For a read, the first GAP cycle sets rd_data, rd_src=g, rd_valid=1 for one cycle.
  - Then go to IDLE. Back-to-back grants are therefore separated by GAP_CYCLES+1 idle-pin cycles.
- Fairness: round-robin. Each continuously valid requester is granted within NREQ frames.
- Dropping req_valid before ready withdraws the request. A valid that drops during IDLE's sampling cycle is still granted, since the word is latched in LOAD; requesters must not drop valid while it is being sampled.
- Simultaneous valids in the same cycle resolve by pointer, never by index alone.
- Counters: bit counter 4 bits, phase counter $clog2(2*CLKDIV) bits, reset counters sized for max(RST_CYCLES, RST_WAIT). No wrap beyond terminal counts.

Test Plan:
- Reset release, CLKDIV=2, RST_CYCLES=4, RST_WAIT=8, req_valid[0] held from cycle 0 -> rst_n rises at cycle 4; req_ready[0] pulses exactly once at cycle 13; sen_n low for 65 cycles.
- Write 0x0A55 from requester 1 -> sdio bit sequence 0000101001010101 on 16 sclk rising edges; no rd_valid.
- Read 0x8F00 from requester 2, sdo model returning 0xC3 -> sdio driven 0 for the data bits; rd_valid single pulse with rd_data=0xC3, rd_src=2 in the first GAP cycle.
- All three valids held continuously -> grant order 0,1,2,0,1,2; sen_n high for at least GAP_CYCLES between frames.
- Async rst asserted at bit 7 of a frame -> same cycle sen_n=1, sclk=0, rst_n=0; full RST_HOLD/RST_WAIT replays; the aborted requester is re-granted only after RST_WAIT.
- Valid pulsed 1 cycle in RST_WAIT, then dropped -> no grant, no SPI activity, busy falls on entry to IDLE.
